// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V control slice.
//   ctrl_state_t   : controller FSM states
//   OPCODE_OP      : R-type ALU opcode (0110011)
//   OPCODE_OP_IMM  : I-type ALU opcode (0010011)
//   PC_STEP        : sequential PC increment in bytes
//   is_legal_opcode: true for the opcodes this controller executes
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK,
    TRAP
  } ctrl_state_t;

  localparam logic [6:0]  OPCODE_OP     = 7'b0110011;
  localparam logic [6:0]  OPCODE_OP_IMM = 7'b0010011;
  localparam int unsigned PC_STEP       = 4;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    return (op == OPCODE_OP) || (op == OPCODE_OP_IMM);
  endfunction

endpackage

// File: rtl/riscv_mc_ctrl_instret_counter.sv
// Retired-instruction counter, only instantiated when RISCV_INSTRET_EN is
// defined.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, clears count
//   inc   : add one this cycle
//   count : 32-bit count, wraps at 2^32
module instret_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RISC-V control FSM: IDLE -> FETCH -> DECODE -> EXECUTE ->
// WRITEBACK, with an absorbing TRAP on any opcode other than OP / OP-IMM.
// Optional macro RISCV_INSTRET_EN adds the retired-instruction counter;
// without it instret reads constant zero.
//   clk, rst       : clock / asynchronous active-high reset
//   run            : level enable for starting / continuing execution
//   imem_req/addr  : fetch request and address (address is pc)
//   imem_ack/rdata : fetch completion and instruction word
//   pc, ir         : program counter and latched instruction
//   alu_src        : 1 = immediate operand (valid EXECUTE..WRITEBACK)
//   rf_we, retire  : WRITEBACK strobes
//   busy, illegal  : activity status and sticky illegal-opcode flag
//   instret        : retired-instruction count
module riscv_mc_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     ir,
  output logic            alu_src,
  output logic            rf_we,
  output logic            retire,
  output logic            busy,
  output logic            illegal,
  output logic [31:0]     instret
);

  ctrl_state_t state;

  assign imem_addr = pc;
  assign busy      = (state != IDLE) && (state != TRAP);

  // Strobes are registered and set on the transition into the state that
  // owns them, so each is high for exactly the cycles of that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      ir       <= '0;
      illegal  <= 1'b0;
      imem_req <= 1'b0;
      alu_src  <= 1'b0;
      rf_we    <= 1'b0;
      retire   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= DECODE;
          end
        end
        DECODE: begin
          if (is_legal_opcode(ir[6:0])) begin
            state   <= EXECUTE;
            alu_src <= (ir[6:0] == OPCODE_OP_IMM);
          end else begin
            state   <= TRAP;
            illegal <= 1'b1;
          end
        end
        EXECUTE: begin
          state  <= WRITEBACK;
          rf_we  <= (ir[11:7] != 5'd0);
          retire <= 1'b1;
        end
        WRITEBACK: begin
          rf_we   <= 1'b0;
          retire  <= 1'b0;
          alu_src <= 1'b0;
          pc      <= pc + XLEN'(PC_STEP);
          if (run) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        TRAP: begin
          state <= TRAP;
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
          alu_src  <= 1'b0;
          rf_we    <= 1'b0;
          retire   <= 1'b0;
        end
      endcase
    end
  end

`ifdef RISCV_INSTRET_EN
  instret_counter u_instret (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire),
    .count (instret)
  );
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
module tb_riscv_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        imem_req, alu_src, rf_we, retire, busy, illegal;
  logic [31:0] imem_addr, pc, ir, instret;

  logic        imem_req2, alu_src2, rf_we2, retire2, busy2, illegal2;
  logic [31:0] imem_addr2, pc2, ir2, instret2;

  riscv_mc_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc), .ir(ir),
    .alu_src(alu_src), .rf_we(rf_we), .retire(retire), .busy(busy),
    .illegal(illegal), .instret(instret)
  );

  // Lockstep copy with a reset PC just below the wrap point.
  riscv_mc_ctrl #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .run(run), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc2), .ir(ir2),
    .alu_src(alu_src2), .rf_we(rf_we2), .retire(retire2), .busy(busy2),
    .illegal(illegal2), .instret(instret2)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] ir;
    logic        we;
    logic        src;
    logic [31:0] pc;
    int unsigned cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] rd;
    int unsigned dly;
    logic        we;
    logic        src;
  } vec_t;

  logic [31:0] exp_pc;

  // Monitor: every retire pulse must match the oldest issued instruction.
  always @(negedge clk) begin
    if (!rst) begin
      if (retire) begin
        if (sb.size() == 0) begin
          chk("retire_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wb_ir", ir, e.ir);
          chk("wb_rf_we", {31'd0, rf_we}, {31'd0, e.we});
          chk("wb_alu_src", {31'd0, alu_src}, {31'd0, e.src});
          chk("wb_pc", pc, e.pc);
          chk("wb_cycle", cyc, e.cyc);
        end
      end else if (rf_we) begin
        chk("rf_we_without_retire", 32'd1, 32'd0);
      end
    end
  end

  task automatic issue(input logic [31:0] rd, input int unsigned dly, input logic we, input logic src);
    int unsigned n;
    int unsigned start;
    exp_t e;
    n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      chk("req_timeout", 32'd0, 32'd1);
      return;
    end
    start = cyc;
    e.ir = rd; e.we = we; e.src = src; e.pc = exp_pc; e.cyc = start + dly + 3;
    sb.push_back(e);
    for (int unsigned k = 0; k < dly; k++) begin
      chk("wait_addr", imem_addr, exp_pc);
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
    end
    chk("ack_addr", imem_addr, exp_pc);
    imem_ack   = 1'b1;
    imem_rdata = rd;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0000_006F;
    exp_pc     = exp_pc + 32'd4;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h0010_0293, 1, 1'b1, 1'b1};  // addi x5,x0,1
    vecs[1] = '{32'h0053_02B3, 0, 1'b1, 1'b0};  // add x5,x6,x5
    vecs[2] = '{32'h0000_0033, 2, 1'b0, 1'b0};  // add x0,x0,x0
    vecs[3] = '{32'hFFF0_0F93, 0, 1'b1, 1'b1};  // addi x31,x0,-1
    vecs[4] = '{32'h4020_8233, 2, 1'b1, 1'b0};  // sub x4,x1,x2
    vecs[5] = '{32'h0000_0013, 0, 1'b0, 1'b1};  // addi x0,x0,0

    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    exp_pc = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_wrapdut", pc2, 32'hFFFF_FFFC);
    chk("rst_ir", ir, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_instret", instret, 32'd0);

    rst = 1'b0;
    run = 1'b1;
    issue(32'h0050_0093, 0, 1'b1, 1'b1);  // addi x1,x0,5
    for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
    chk("pc_after_first", pc, 32'h4);
    chk("pc_wrap", pc2, 32'h0);
    issue(32'h0020_81B3, 3, 1'b1, 1'b0);  // add x3,x1,x2
    issue(32'h0000_0013, 0, 1'b0, 1'b1);  // addi x0,x0,0

    // Drop run while the instruction is in EXECUTE; it must still retire.
    issue(32'h00A0_0113, 0, 1'b1, 1'b1);  // addi x2,x0,10
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    repeat (3) @(negedge clk);
    chk("idle_pc", pc, exp_pc);
    chk("idle_req_hold", {31'd0, imem_req}, 32'd0);

    run = 1'b1;
    foreach (vecs[i]) issue(vecs[i].rd, vecs[i].dly, vecs[i].we, vecs[i].src);

    // jal: illegal for this controller, ends in TRAP.
    issue(32'h0000_006F, 0, 1'b0, 1'b0);
    void'(sb.pop_back());
    @(negedge clk);
    @(negedge clk);
    chk("trap_illegal", {31'd0, illegal}, 32'd1);
    chk("trap_busy", {31'd0, busy}, 32'd0);
    chk("trap_pc", pc, 32'd40);
`ifdef RISCV_INSTRET_EN
    chk("instret", instret, 32'd10);
`else
    chk("instret", instret, 32'd0);
`endif
    imem_ack = 1'b1;
    imem_rdata = 32'h0050_0093;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("trap_ir_hold", ir, 32'h0000_006F);
    for (int i = 0; i < 8; i++) begin
      chk("trap_req", {31'd0, imem_req}, 32'd0);
      chk("trap_pc_frozen", pc, 32'd40);
      @(negedge clk);
    end

    // Reset during a stalled fetch must drop the request immediately.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_pc = 32'h0;
    for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
    chk("refetch_req", {31'd0, imem_req}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", {31'd0, imem_req}, 32'd0);
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_illegal", {31'd0, illegal}, 32'd0);
    chk("async_rst_instret", instret, 32'd0);
    @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
